// File: rtl/normalizer_pipe_if.sv
// ---------------------------------------------------------------------------
// normalizer_pipe_pkg / normalizer_pipe_if
//
// Purpose
//   The format enum that the post-add normaliser uses, and the interface that
//   carries the normaliser's input beat and result beat. Each side has its own
//   valid/ready handshake.
//
// Interface signals (W = fraction width, TAG_W = tag width, CW = count width)
//   fmt         fp_fmt_e  FP32 selects single lane; FP16/BF16 select dual lane
//   in_valid    1         input beat valid
//   in_ready    1         normaliser can take a beat this cycle
//   in_x        W         fraction to normalise
//   in_tag      TAG_W     sideband tag travelling with the beat
//   out_valid   1         result valid
//   out_ready   1         downstream accepts the result
//   out_r       W         normalised fraction
//   out_cnt_h   CW        single: word LZC, dual: high-lane LZC
//   out_cnt_l   CW        dual: low-window LZC, single: 0
//   out_zero_h  1         single: word is zero, dual: high lane is zero
//   out_zero_l  1         dual: low window is zero, single: 0
//   out_tag     TAG_W     tag of the result beat
//
// Modports
//   master : the environment. It drives the input beat and out_ready.
//   slave  : the normaliser. It drives in_ready and the result beat.
// ---------------------------------------------------------------------------
package normalizer_pipe_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        BF16 = 2'd2
    } fp_fmt_e;

endpackage

interface normalizer_pipe_if
    import normalizer_pipe_pkg::*;
#(
    parameter int W     = 28,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(W + 1);

    fp_fmt_e          fmt;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_r;
    logic [CW-1:0]    out_cnt_h;
    logic [CW-1:0]    out_cnt_l;
    logic             out_zero_h;
    logic             out_zero_l;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output fmt, in_valid, in_x, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_cnt_h, out_cnt_l,
               out_zero_h, out_zero_l, out_tag
    );

    modport slave (
        input  fmt, in_valid, in_x, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_cnt_h, out_cnt_l,
               out_zero_h, out_zero_l, out_tag
    );

endinterface

// File: rtl/normalizer_pipe.sv
// ---------------------------------------------------------------------------
// normalizer_pipe
//
// Purpose
//   Pipelined post-add normaliser. It counts leading zeros and left-shifts so
//   that the leading one ends up at the top of its lane. A valid/ready
//   handshake controls the flow on both sides.
//   - FP32 mode has one lane that covers the whole W-bit word.
//   - FP16/BF16 mode has two independent lanes:
//       high lane  X[W-1:W/2]
//       low window X[W/2-1-LO_OFS:0]
//     The LO_OFS gap bits above the low window are ignored on input and are
//     driven to zero on output.
//   An all-zero lane gives a zero result, sets the zero flag and reports a
//   count equal to the lane width.
//
// Parameters
//   W       fraction width, even, >= 8
//   LO_OFS  number of gap bits at the top of the low half
//   PIPE    number of register stages, 1 or 2
//   TAG_W   sideband tag width
//
// Ports
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus     normalizer_pipe_if slave modport (input beat and result beat)
// ---------------------------------------------------------------------------
module normalizer_pipe
    import normalizer_pipe_pkg::*;
#(
    parameter int W      = 28,
    parameter int LO_OFS = 2,
    parameter int PIPE   = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    normalizer_pipe_if.slave bus
);

    localparam int CW       = $clog2(W + 1);
    localparam int HW       = W / 2;
    localparam int LW       = HW - LO_OFS;
    // The two largest shift steps (16 and 8 when W = 28) run before the
    // stage-0 register when PIPE = 2.
    localparam int SPLIT    = CW - 2;
    localparam int FRONT_LO = (PIPE == 2) ? SPLIT : 0;

    if (W < 8 || (W % 2) != 0) begin : g_bad_w
        $error("normalizer_pipe: W must be even and at least 8");
    end
    if (LO_OFS < 0 || LO_OFS >= HW) begin : g_bad_lo_ofs
        $error("normalizer_pipe: LO_OFS must lie in 0..W/2-1");
    end
    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("normalizer_pipe: PIPE must be 1 or 2");
    end

    // Each lane is held left-aligned in a full W-bit vector, with zeros
    // filling the bits below the lane. This lets one shifter handle every
    // lane width.
    typedef struct packed {
        logic [W-1:0]  v;
        logic [CW-1:0] c;
    } lane_t;

    typedef struct packed {
        logic [W-1:0]  r;
        logic [CW-1:0] cnt_h;
        logic [CW-1:0] cnt_l;
        logic          zero_h;
        logic          zero_l;
    } result_t;

    // Radix-2 leading-zero shifter. It applies only the shift steps 2^k with
    // lo <= k <= hi. A non-zero lane's leading one always lies inside the
    // lane, so the zero fill below the lane can never be shifted into view.
    // For a zero lane the raw count is garbage (31 when W = 28); assemble()
    // replaces that count.
    function automatic lane_t norm_steps(lane_t s_in, int hi, int lo);
        lane_t s;
        s = s_in;
        for (int k = CW - 1; k >= 0; k--) begin
            if (k <= hi && k >= lo) begin
                int sh;
                sh = 1 << k;
                if ((s.v >> (W - sh)) == '0) begin
                    s.v = s.v << sh;
                    s.c = s.c + CW'(sh);
                end
            end
        end
        return s;
    endfunction

    // Places the lane results back into their output bit positions and
    // applies the zero-lane count override.
    function automatic result_t assemble(logic single, lane_t a, logic za,
                                         lane_t b, logic zb);
        result_t res;
        res = '0;
        if (single) begin
            res.r      = a.v;
            res.cnt_h  = za ? CW'(W) : a.c;
            res.zero_h = za;
        end else begin
            // The low result is zero-extended into the low half, which
            // forces the gap bits to zero.
            res.r      = {a.v[W-1:HW], {HW{1'b0}}} | W'(b.v[W-1 -: LW]);
            res.cnt_h  = za ? CW'(HW) : a.c;
            res.cnt_l  = zb ? CW'(LW) : b.c;
            res.zero_h = za;
            res.zero_l = zb;
        end
        return res;
    endfunction

    logic             is_single;
    lane_t            a_seed;
    lane_t            b_seed;
    lane_t            a_front;
    lane_t            b_front;
    logic             a_zero;
    logic             b_zero;

    logic             out_load;
    logic             in_ready_w;
    logic             src_valid;
    result_t          src_res;
    logic [TAG_W-1:0] src_tag;

    logic             out_valid_q;
    result_t          out_res_q;
    logic [TAG_W-1:0] out_tag_q;

    // Input side. Lane A is the whole word in FP32 mode and the high half in
    // dual mode. Lane B is always the low window; its result is discarded in
    // FP32 mode.
    always_comb begin
        is_single = (bus.fmt == FP32);
        a_seed    = '0;
        b_seed    = '0;
        a_seed.v  = is_single ? bus.in_x : {bus.in_x[W-1:HW], {HW{1'b0}}};
        b_seed.v  = {bus.in_x[LW-1:0], {(W - LW){1'b0}}};
        a_zero    = (a_seed.v == '0);
        b_zero    = (b_seed.v == '0);
        a_front   = norm_steps(a_seed, CW - 1, FRONT_LO);
        b_front   = norm_steps(b_seed, CW - 1, FRONT_LO);
    end

    // The output register can load when it is empty or when its beat is
    // draining this cycle.
    assign out_load = !out_valid_q || bus.out_ready;

    if (PIPE == 2) begin : g_pipe2
        logic             s0_valid;
        logic             s0_single;
        logic             s0_za;
        logic             s0_zb;
        lane_t            s0_a;
        lane_t            s0_b;
        logic [TAG_W-1:0] s0_tag;
        logic             s0_load;
        lane_t            a_back;
        lane_t            b_back;

        assign s0_load = !s0_valid || out_load;

        // Stage 0 holds the partly shifted lanes, the zero flags, the format
        // and the tag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_valid  <= 1'b0;
                s0_single <= 1'b0;
                s0_za     <= 1'b0;
                s0_zb     <= 1'b0;
                s0_a      <= '0;
                s0_b      <= '0;
                s0_tag    <= '0;
            end else if (s0_load) begin
                s0_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s0_single <= is_single;
                    s0_za     <= a_zero;
                    s0_zb     <= b_zero;
                    s0_a      <= a_front;
                    s0_b      <= b_front;
                    s0_tag    <= bus.in_tag;
                end
            end
        end

        // Second half of the shifter: the 4/2/1 steps when W = 28.
        always_comb begin
            a_back  = norm_steps(s0_a, SPLIT - 1, 0);
            b_back  = norm_steps(s0_b, SPLIT - 1, 0);
            src_res = assemble(s0_single, a_back, s0_za, b_back, s0_zb);
        end

        assign in_ready_w = s0_load;
        assign src_valid  = s0_valid;
        assign src_tag    = s0_tag;
    end else begin : g_pipe1
        always_comb begin
            src_res = assemble(is_single, a_front, a_zero, b_front, b_zero);
        end

        assign in_ready_w = out_load;
        assign src_valid  = bus.in_valid;
        assign src_tag    = bus.in_tag;
    end

    // Output register. Data only changes when a new beat loads, so a stalled
    // result holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
        end else if (out_load) begin
            out_valid_q <= src_valid;
            if (src_valid) begin
                out_res_q <= src_res;
                out_tag_q <= src_tag;
            end
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_r      = out_res_q.r;
    assign bus.out_cnt_h  = out_res_q.cnt_h;
    assign bus.out_cnt_l  = out_res_q.cnt_l;
    assign bus.out_zero_h = out_res_q.zero_h;
    assign bus.out_zero_l = out_res_q.zero_l;
    assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_normalizer_pipe.sv
// ---------------------------------------------------------------------------
// tb_normalizer_pipe
//
// Drives two copies of normalizer_pipe, one with PIPE=1 and one with PIPE=2,
// from a shared input stream and a shared out_ready.
// - Each copy has its own scoreboard queue. The queue is loaded with the
//   expected result whenever that copy accepts a beat, and is drained
//   whenever that copy delivers a result.
// - The expected results come from a bit-serial leading-zero model.
// - While a result is stalled, its outputs are checked to stay unchanged.
// ---------------------------------------------------------------------------
module tb_normalizer_pipe;
    import normalizer_pipe_pkg::*;

    typedef struct packed {
        logic [27:0] r;
        logic [4:0]  cnt_h;
        logic [4:0]  cnt_l;
        logic        zero_h;
        logic        zero_l;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    fp_fmt_e     fmt_s = FP32;
    logic        in_valid = 1'b0;
    logic [27:0] x_s = '0;
    logic [3:0]  tag_s = '0;
    logic        out_ready = 1'b1;
    exp_t        drive_exp = '0;

    int compare_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    // Every comparison in the bench goes through this task.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        compare_count++;
        if (act !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: scans for the leading one one bit at a time.
    function automatic exp_t model(fp_fmt_e f, logic [27:0] x, logic [3:0] t);
        exp_t        e;
        int          n;
        int          m;
        logic [13:0] h;
        logic [11:0] l;
        e = '0;
        e.tag = t;
        if (f == FP32) begin
            n = 0;
            while (n < 28 && x[27-n] == 1'b0) n++;
            e.cnt_h  = 5'(n);
            e.zero_h = (n == 28);
            e.r      = x << n;
        end else begin
            h = x[27:14];
            l = x[11:0];
            n = 0;
            while (n < 14 && h[13-n] == 1'b0) n++;
            m = 0;
            while (m < 12 && l[11-m] == 1'b0) m++;
            h = h << n;
            l = l << m;
            e.r      = {h, 2'b00, l};
            e.cnt_h  = 5'(n);
            e.cnt_l  = 5'(m);
            e.zero_h = (n == 14);
            e.zero_l = (m == 12);
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int P = g + 1;

        normalizer_pipe_if #(.W(28), .TAG_W(4)) bus ();

        assign bus.fmt       = fmt_s;
        assign bus.in_valid  = in_valid;
        assign bus.in_x      = x_s;
        assign bus.in_tag    = tag_s;
        assign bus.out_ready = out_ready;

        normalizer_pipe #(.W(28), .LO_OFS(2), .PIPE(P), .TAG_W(4)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        exp_t sbq[$];
        logic held = 1'b0;
        exp_t last = '0;

        // Monitor. It samples on the falling edge, when inputs and outputs
        // are settled for the next rising edge.
        always @(negedge clk) begin
            exp_t e;
            exp_t cur;
            cur = {bus.out_r, bus.out_cnt_h, bus.out_cnt_l,
                   bus.out_zero_h, bus.out_zero_l, bus.out_tag};
            if (!rst_n) begin
                sbq.delete();
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput($sformatf("p%0d_hold_valid", P), 32'(bus.out_valid), 32'd1);
                    checkOutput($sformatf("p%0d_hold_r", P), 32'(cur.r), 32'(last.r));
                    checkOutput($sformatf("p%0d_hold_meta", P), 32'(cur[17:0]), 32'(last[17:0]));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        checkOutput($sformatf("p%0d_unexpected_beat", P), 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput($sformatf("p%0d_r", P), 32'(cur.r), 32'(e.r));
                        checkOutput($sformatf("p%0d_cnt_h", P), 32'(cur.cnt_h), 32'(e.cnt_h));
                        checkOutput($sformatf("p%0d_cnt_l", P), 32'(cur.cnt_l), 32'(e.cnt_l));
                        checkOutput($sformatf("p%0d_zero_h", P), 32'(cur.zero_h), 32'(e.zero_h));
                        checkOutput($sformatf("p%0d_zero_l", P), 32'(cur.zero_l), 32'(e.zero_l));
                        checkOutput($sformatf("p%0d_tag", P), 32'(cur.tag), 32'(e.tag));
                    end
                end
                held = bus.out_valid && !bus.out_ready;
                last = cur;
                if (bus.in_valid && bus.in_ready) sbq.push_back(drive_exp);
            end
        end
    end

    // Presents one beat and holds it until the PIPE=2 copy takes it. The PIPE=1
    // copy accepts whenever it is ready; its scoreboard follows its own accepts.
    task automatic applyStimulus(input fp_fmt_e f, input logic [27:0] x,
                                 input logic [3:0] t, input exp_t e);
        logic ok;
        fmt_s = f;
        x_s = x;
        tag_s = t;
        drive_exp = e;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = lane[1].bus.in_ready;
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainAll();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (lane[0].sbq.size() == 0 && lane[1].sbq.size() == 0 &&
                !lane[0].bus.out_valid && !lane[1].bus.out_valid) break;
        end
        checkOutput("p1_drain_left", 32'(lane[0].sbq.size()), 32'd0);
        checkOutput("p2_drain_left", 32'(lane[1].sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] randomX(fp_fmt_e f);
        logic [27:0] x;
        int          sel;
        x = 28'($urandom) >> $urandom_range(0, 28);
        if (f != FP32) x[11:0] = 12'($urandom) >> $urandom_range(0, 12);
        sel = $urandom_range(0, 9);
        if (sel == 0) x = '0;
        else if (sel == 1) x[27:14] = '0;
        else if (sel == 2) x[11:0] = '0;
        return x;
    endfunction

    initial begin
        exp_t        e;
        fp_fmt_e     f;
        logic [27:0] x;
        logic [3:0]  t;

        // Reset state
        #2;
        checkOutput("p1_reset_valid", 32'(lane[0].bus.out_valid), 32'd0);
        checkOutput("p2_reset_valid", 32'(lane[1].bus.out_valid), 32'd0);
        checkOutput("p2_reset_r", 32'(lane[1].bus.out_r), 32'd0);
        checkOutput("p2_reset_tag", 32'(lane[1].bus.out_tag), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("p1_ready_after_reset", 32'(lane[0].bus.in_ready), 32'd1);
        checkOutput("p2_ready_after_reset", 32'(lane[1].bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases with fixed expectations
        e = '0; e.r = 28'h8000000; e.cnt_h = 5'd27; e.tag = 4'h1;
        applyStimulus(FP32, 28'h0000001, 4'h1, e);
        e = '0; e.cnt_h = 5'd28; e.zero_h = 1'b1; e.tag = 4'h2;
        applyStimulus(FP32, 28'h0000000, 4'h2, e);
        e = '0; e.r = {14'h2000, 14'h0880}; e.cnt_h = 5'd7; e.cnt_l = 5'd7; e.tag = 4'h3;
        applyStimulus(FP16, {14'h0040, 14'h3011}, 4'h3, e);
        e = '0; e.cnt_h = 5'd14; e.cnt_l = 5'd12; e.zero_h = 1'b1; e.zero_l = 1'b1; e.tag = 4'h4;
        applyStimulus(BF16, {14'h0000, 14'h3000}, 4'h4, e);
        drainAll();

        // Backpressure: PIPE=2 holds two beats, then stalls
        out_ready = 1'b0;
        applyStimulus(FP32, 28'h0100000, 4'h1, model(FP32, 28'h0100000, 4'h1));
        applyStimulus(FP16, 28'h0012345, 4'h2, model(FP16, 28'h0012345, 4'h2));
        fmt_s = FP32; x_s = 28'h0000300; tag_s = 4'h3;
        drive_exp = model(FP32, 28'h0000300, 4'h3);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("p2_full_ready", 32'(lane[1].bus.in_ready), 32'd0);
            checkOutput("p2_full_tag", 32'(lane[1].bus.out_tag), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(FP32, 28'h0000300, 4'h3, model(FP32, 28'h0000300, 4'h3));
        applyStimulus(BF16, 28'h8000001, 4'h4, model(BF16, 28'h8000001, 4'h4));
        drainAll();

        // Asynchronous reset while a result is waiting
        out_ready = 1'b0;
        applyStimulus(FP32, 28'h0000123, 4'h5, model(FP32, 28'h0000123, 4'h5));
        repeat (3) @(negedge clk);
        checkOutput("p1_valid_before_reset", 32'(lane[0].bus.out_valid), 32'd1);
        checkOutput("p2_valid_before_reset", 32'(lane[1].bus.out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("p1_async_reset", 32'(lane[0].bus.out_valid), 32'd0);
        checkOutput("p2_async_reset", 32'(lane[1].bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("p1_ready_after_rerelease", 32'(lane[0].bus.in_ready), 32'd1);
        checkOutput("p2_ready_after_rerelease", 32'(lane[1].bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("p1_no_stale", 32'(lane[0].bus.out_valid), 32'd0);
            checkOutput("p2_no_stale", 32'(lane[1].bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random stream with random format, valid and out_ready
        for (int c = 0; c < 16000; c++) begin
            f = fp_fmt_e'($urandom_range(0, 2));
            x = randomX(f);
            t = 4'($urandom_range(0, 15));
            fmt_s = f;
            x_s = x;
            tag_s = t;
            drive_exp = model(f, x, t);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
